// File: rtl/quad_pkg.sv
// Shared phase encoding, speed limits and the quadrature step decode used by
// the speed meter front end and top level.
package quad_pkg;

  // Encoded as the raw {a, b} pin pair so a synchronised sample casts directly.
  typedef enum logic [1:0] {
    P00 = 2'b00,
    P01 = 2'b01,
    P11 = 2'b11,
    P10 = 2'b10
  } quad_phase_t;

  typedef struct packed {
    logic signed [1:0] inc;
    logic              illegal;
  } quad_step_t;

  localparam logic signed [15:0] SPEED_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SPEED_MIN = 16'sh8000;
  localparam logic signed [17:0] ACC_MAX   = 18'sd131071;
  localparam logic signed [17:0] ACC_MIN   = -18'sd131071;

  function automatic quad_phase_t quad_next(input quad_phase_t p);
    case (p)
      P00:     quad_next = P01;
      P01:     quad_next = P11;
      P11:     quad_next = P10;
      default: quad_next = P00;
    endcase
  endfunction

  function automatic quad_step_t quad_step(input quad_phase_t prev, input quad_phase_t cur);
    quad_step_t s;
    s.inc     = 2'sd0;
    s.illegal = 1'b0;
    if (cur != prev) begin
      if (cur == quad_next(prev)) begin
        s.inc = 2'sd1;
      end else if (prev == quad_next(cur)) begin
        s.inc = -2'sd1;
      end else begin
        s.illegal = 1'b1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Encoder front end: 2-flop synchronisers, optional per-channel glitch filter
// (QUAD_GLITCH_FILTER_EN), phase register with prime cycle, and step decode.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int DIR_INVERT = 0,
  parameter int FILT_LEN   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enc_a,
  input  logic              i_enc_b,
  output logic signed [1:0] o_inc,
  output logic              o_illegal
);

  if (FILT_LEN < 2 || FILT_LEN > 16) begin : g_bad_filt_len
    $error("quad_decoder: FILT_LEN must be in 2..16");
  end

  // Bit 1 = channel A, bit 0 = channel B throughout.
  logic [1:0] r_enc_p0;
  logic [1:0] r_enc_p1;
  logic [1:0] w_dec;

  // Stage p0/p1: metastability synchroniser (data only, no reset)
  always_ff @(posedge clk) begin
    r_enc_p0 <= {i_enc_a, i_enc_b};
    r_enc_p1 <= r_enc_p0;
  end

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN);

  logic [CNT_W-1:0] r_filt_cnt [2];
  logic [1:0]       r_filt;

  // Stage p2: output follows the input only after FILT_LEN agreeing samples
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        r_filt[i]     <= 1'b0;
        r_filt_cnt[i] <= '0;
      end else if (r_enc_p1[i] == r_filt[i]) begin
        r_filt_cnt[i] <= '0;
      end else if (r_filt_cnt[i] == CNT_W'(FILT_LEN - 1)) begin
        r_filt[i]     <= r_enc_p1[i];
        r_filt_cnt[i] <= '0;
      end else begin
        r_filt_cnt[i] <= r_filt_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign w_dec = r_filt;
`else
  assign w_dec = r_enc_p1;
`endif

  quad_phase_t w_cur;
  quad_phase_t r_prev;
  logic        r_primed;
  quad_step_t  w_step;

  assign w_cur  = quad_phase_t'(w_dec);
  assign w_step = quad_step(r_prev, w_cur);

  // Phase register: the first cycle out of reset only captures the phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev   <= P00;
      r_primed <= 1'b0;
    end else begin
      r_prev   <= w_cur;
      r_primed <= 1'b1;
    end
  end

  always_comb begin
    o_inc     = 2'sd0;
    o_illegal = 1'b0;
    if (r_primed) begin
      o_inc     = (DIR_INVERT != 0) ? -w_step.inc : w_step.inc;
      o_illegal = w_step.illegal;
    end
  end

endmodule

// File: rtl/quad_speed_meter.sv
// Per-wheel quadrature speed meter: position, error count and per-window
// saturated speed. Define QUAD_GLITCH_FILTER_EN to add the input glitch filter.
module quad_speed_meter
  import quad_pkg::*;
#(
  parameter int WINDOW_CYCLES = 500000,
  parameter int DIR_INVERT    = 0,
  parameter int FILT_LEN      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enc_a,
  input  logic               enc_b,
  output logic signed [31:0] speed,
  output logic               speed_valid,
  output logic signed [31:0] position,
  output logic [7:0]         err_cnt
);

  if (WINDOW_CYCLES < 2 || WINDOW_CYCLES > 16777216) begin : g_bad_window
    $error("quad_speed_meter: WINDOW_CYCLES must be in 2..2^24");
  end

  localparam int              WIN_W    = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  function automatic logic signed [17:0] sat_acc(input logic signed [18:0] v);
    if (v > 19'sd131071) begin
      return ACC_MAX;
    end else if (v < -19'sd131071) begin
      return ACC_MIN;
    end
    return v[17:0];
  endfunction

  function automatic logic signed [15:0] sat_speed(input logic signed [18:0] v);
    if (v > 19'sd32767) begin
      return SPEED_MAX;
    end else if (v < -19'sd32768) begin
      return SPEED_MIN;
    end
    return v[15:0];
  endfunction

  logic signed [1:0]  w_inc;
  logic               w_illegal;
  logic signed [18:0] w_sum;
  logic               w_win_end;

  logic [WIN_W-1:0]   r_win;
  logic signed [17:0] r_acc;
  logic signed [15:0] r_speed;
  logic               r_speed_vld;
  logic signed [31:0] r_position;
  logic [7:0]         r_err;

  quad_decoder #(
    .DIR_INVERT(DIR_INVERT),
    .FILT_LEN  (FILT_LEN)
  ) u_dec (
    .clk      (clk),
    .reset    (reset),
    .i_enc_a  (enc_a),
    .i_enc_b  (enc_b),
    .o_inc    (w_inc),
    .o_illegal(w_illegal)
  );

  // The window-end cycle's own increment is folded into the closing window.
  assign w_sum     = 19'(r_acc) + 19'(w_inc);
  assign w_win_end = (r_win == WIN_LAST);

  // Stage p3: counters, window accumulation and speed latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win       <= '0;
      r_acc       <= '0;
      r_speed     <= '0;
      r_speed_vld <= 1'b0;
      r_position  <= '0;
      r_err       <= '0;
    end else begin
      r_position  <= r_position + 32'(w_inc);
      r_speed_vld <= w_win_end;
      if (w_illegal && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
      if (w_win_end) begin
        r_win   <= '0;
        r_acc   <= '0;
        r_speed <= sat_speed(w_sum);
      end else begin
        r_win <= r_win + WIN_W'(1);
        r_acc <= sat_acc(w_sum);
      end
    end
  end

  assign speed       = 32'(r_speed);
  assign speed_valid = r_speed_vld;
  assign position    = r_position;
  assign err_cnt     = r_err;

endmodule

// File: tb/tb_quad_speed_meter.sv
// Directed bench for quad_speed_meter: normal and inverted instances share one
// encoder; a second pair with a long window covers speed saturation.
module tb_quad_speed_meter;

  localparam int W_MAIN = 10000;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int LAT       = 7;
  localparam int HOLD      = 6;
  localparam int SAT_EDGES = 34000;
  localparam int SAT_SP    = 2;
`else
  localparam int LAT       = 3;
  localparam int HOLD      = 2;
  localparam int SAT_EDGES = 40000;
  localparam int SAT_SP    = 1;
`endif
  localparam int W_SAT = SAT_EDGES * SAT_SP + 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sat_rst = 1'b1;
  logic enc_a = 1'b0, enc_b = 1'b0, sat_a = 1'b0, sat_b = 1'b0;

  logic [31:0] m_speed, m_pos, i_speed, i_pos, s_speed, s_pos, si_speed, si_pos;
  logic        m_vld, i_vld, s_vld, si_vld;
  logic [7:0]  m_err, i_err, s_err, si_err;

  int total = 0;
  int bad = 0;
  int cyc = 0, npulse = 0, last_pulse = 0, gap = 0, multi = 0;
  bit prev_vld = 1'b0;
  bit sat_done = 1'b0;
  int ph = 0;
  int exp_pos = 0;

  always #5 clk = ~clk;

  quad_speed_meter #(.WINDOW_CYCLES(W_MAIN), .DIR_INVERT(0), .FILT_LEN(4)) dut_main (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .speed(m_speed), .speed_valid(m_vld), .position(m_pos), .err_cnt(m_err));

  quad_speed_meter #(.WINDOW_CYCLES(W_MAIN), .DIR_INVERT(1), .FILT_LEN(4)) dut_inv (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .speed(i_speed), .speed_valid(i_vld), .position(i_pos), .err_cnt(i_err));

  quad_speed_meter #(.WINDOW_CYCLES(W_SAT), .DIR_INVERT(0), .FILT_LEN(4)) dut_sat (
    .clk(clk), .reset(sat_rst), .enc_a(sat_a), .enc_b(sat_b),
    .speed(s_speed), .speed_valid(s_vld), .position(s_pos), .err_cnt(s_err));

  quad_speed_meter #(.WINDOW_CYCLES(W_SAT), .DIR_INVERT(1), .FILT_LEN(4)) dut_sat_inv (
    .clk(clk), .reset(sat_rst), .enc_a(sat_a), .enc_b(sat_b),
    .speed(si_speed), .speed_valid(si_vld), .position(si_pos), .err_cnt(si_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ph2ab(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic step(input int dir);
    ph = (ph + dir) & 3;
    {enc_a, enc_b} = ph2ab(ph);
    exp_pos += dir;
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < W_MAIN + 100; n++) begin
      @(negedge clk);
      if (m_vld) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (m_vld) begin
      npulse++;
      gap = cyc - last_pulse;
      last_pulse = cyc;
      if (prev_vld) multi++;
    end
    prev_vld = m_vld;
  end

  initial begin
    bit ok;
    int pos0;
    int nv;

    repeat (5) tick();
    chk("rst_speed", m_speed, 32'd0);
    chk("rst_vld", {31'd0, m_vld}, 32'd0);
    chk("rst_pos", m_pos, 32'd0);
    chk("rst_err", {24'd0, m_err}, 32'd0);

    reset = 1'b0;
    tick();
    for (int i = 0; i < 400; i++) begin
      step(1);
      repeat (20) tick();
    end
    chk("fwd_pos", m_pos, 32'd400);
    chk("fwd_pos_inv", i_pos, -32'sd400);

    for (int i = 0; i < 1500 && npulse < 2; i++) begin
      step(1);
      repeat (20) tick();
    end
    chk("fwd_pulses", npulse, 2);
    chk("fwd_speed", m_speed, 32'h0000_01F4);
    chk("fwd_speed_inv", i_speed, 32'hFFFF_FE0C);
    chk("win_gap", gap, W_MAIN);

    wait_pulse(ok);
    chk("pulse3", {31'd0, ok}, 32'd1);
    pos0 = exp_pos;
    for (int i = 0; i < 250; i++) begin
      step(-1);
      repeat (20) tick();
    end
    wait_pulse(ok);
    chk("pulse4", {31'd0, ok}, 32'd1);
    chk("rev_speed", m_speed, 32'hFFFF_FF06);
    chk("rev_speed_inv", i_speed, 32'd250);
    chk("rev_vld_inv", {31'd0, i_vld}, 32'd1);
    chk("rev_pos", m_pos, pos0 - 250);
    chk("rev_pos_inv", i_pos, 250 - pos0);

    for (int i = 0; i < 300; i++) begin
      {enc_a, enc_b} = ~{enc_a, enc_b};
      repeat (HOLD) tick();
      if (i == 9) begin
        repeat (LAT) tick();
        chk("err_10", {24'd0, m_err}, 32'd10);
      end
    end
    repeat (LAT) tick();
    chk("err_sat", {24'd0, m_err}, 32'd255);
    chk("err_sat_inv", {24'd0, i_err}, 32'd255);
    chk("err_pos", m_pos, exp_pos);
    wait_pulse(ok);
    chk("pulse5", {31'd0, ok}, 32'd1);
    chk("err_speed", m_speed, 32'd0);

    repeat (W_MAIN - LAT) tick();
    step(1);
    tick();
    step(1);
    wait_pulse(ok);
    chk("pulse6", {31'd0, ok}, 32'd1);
    chk("bnd_close", m_speed, 32'd1);
    wait_pulse(ok);
    chk("pulse7", {31'd0, ok}, 32'd1);
    chk("bnd_next", m_speed, 32'd1);

    repeat (100) tick();
    for (int i = 0; i < 4; i++) begin
      step(1);
      repeat (20) tick();
    end
    while (ph != 0) begin
      step(1);
      repeat (20) tick();
    end
    chk("pre_rst_pos", m_pos, exp_pos);
    reset = 1'b1;
    tick();
    chk("mid_rst_speed", m_speed, 32'd0);
    chk("mid_rst_vld", {31'd0, m_vld}, 32'd0);
    chk("mid_rst_pos", m_pos, 32'd0);
    chk("mid_rst_err", {24'd0, m_err}, 32'd0);
    chk("mid_rst_pos_inv", i_pos, 32'd0);
    exp_pos = 0;
    tick();
    reset = 1'b0;
    nv = 0;
    repeat (200) begin
      tick();
      if (m_vld) nv++;
    end
    chk("no_vld_after_rst", nv, 0);

    step(1);
    repeat (LAT - 1) tick();
    chk("lat_before", m_pos, exp_pos - 1);
    tick();
    chk("lat_after", m_pos, exp_pos);

`ifdef QUAD_GLITCH_FILTER_EN
    enc_a = ~enc_a;
    repeat (2) tick();
    enc_a = ~enc_a;
    repeat (12) tick();
    chk("glitch_pos", m_pos, exp_pos);
    chk("glitch_err", {24'd0, m_err}, 32'd0);
`endif

    chk("vld_width", multi, 0);

    for (int n = 0; n < 100000 && !sat_done; n++) tick();
    chk("sat_done", {31'd0, sat_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int sph;
    bit got;
    sph = 0;
    repeat (5) tick();
    sat_rst = 1'b0;
    for (int i = 0; i < SAT_EDGES; i++) begin
      repeat (SAT_SP) tick();
      sph = (sph + 1) & 3;
      {sat_a, sat_b} = ph2ab(sph);
    end
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (s_vld) got = 1'b1;
    end
    chk("sat_pulse", {31'd0, got}, 32'd1);
    chk("sat_vld_inv", {31'd0, si_vld}, 32'd1);
    chk("sat_speed", s_speed, 32'h0000_7FFF);
    chk("sat_speed_inv", si_speed, 32'hFFFF_8000);
    chk("sat_pos", s_pos, SAT_EDGES);
    chk("sat_pos_inv", si_pos, -SAT_EDGES);
    chk("sat_err", {16'd0, s_err, si_err}, 32'd0);
    sat_done = 1'b1;
  end

endmodule
